// File: rtl/ex_muldiv_unit_pkg.sv
// Shared op codes, FSM state encoding and op-decode helpers for the EX-stage mul/div unit.
package ex_muldiv_unit_pkg;

  localparam logic [1:0] EXE_MD_MULT  = 2'b00;
  localparam logic [1:0] EXE_MD_MULTU = 2'b01;
  localparam logic [1:0] EXE_MD_DIV   = 2'b10;
  localparam logic [1:0] EXE_MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_MUL  = 2'b01,
    MD_DIV  = 2'b10,
    MD_DONE = 2'b11
  } md_state_t;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == EXE_MD_MULT) || (op == EXE_MD_DIV);
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_div_core.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per cycle.
// done_c and the quotient/remainder outputs are valid together in the final iteration cycle.
module ex_muldiv_unit_div_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done_c,
  output logic [WIDTH-1:0] quot_c,
  output logic [WIDTH-1:0] rem_c
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned RW = 2 * WIDTH + 1;

  logic             busy_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] dsor_q;
  logic [RW-1:0]    rem_q;
  logic [RW-1:0]    shifted;
  logic [RW-1:0]    rem_next;
  logic [WIDTH+1:0] diff;

  // {partial remainder, dividend/quotient}: shift, trial-subtract, restore on borrow
  always_comb begin
    shifted  = rem_q << 1;
    diff     = {1'b0, shifted[RW-1:WIDTH]} - {2'b00, dsor_q};
    rem_next = diff[WIDTH+1] ? shifted
                             : {diff[WIDTH:0], shifted[WIDTH-1:1], 1'b1};
    done_c   = busy_q && (cnt_q == CW'(WIDTH - 1));
    quot_c   = rem_next[WIDTH-1:0];
    rem_c    = WIDTH'(rem_next[RW-1:WIDTH]);
  end

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      dsor_q <= '0;
      rem_q  <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      dsor_q <= divisor;
      rem_q  <= {(WIDTH + 1)'(0), dividend};
    end else if (busy_q) begin
      rem_q <= rem_next;
      cnt_q <= cnt_q + CW'(1);
      if (done_c) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit beside the EX-stage ALU; returns {hi,lo} and
// stalls the pipeline while working. Signs are stripped on entry and restored on entry to DONE.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter bit          MUL_FAST = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o,
  output logic               div_by_zero_o
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned PW = 2 * WIDTH;

  md_state_t        state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] mcand_q;
  logic [PW-1:0]    acc_q;
  logic             neg_lo_q;
  logic             neg_hi_q;

  logic             sgn, a_neg, b_neg, accept, div_start;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [PW-1:0]    mul_next, mul_fixed, prod_fast, prod_fast_fixed;
  logic             div_done_c;
  logic [WIDTH-1:0] quot_c, rem_c, quot_fixed, rem_fixed;

  // Operand magnitudes, shift-add step and sign restoration
  always_comb begin
    sgn             = op_is_signed(op_i);
    a_neg           = sgn & a_i[WIDTH-1];
    b_neg           = sgn & b_i[WIDTH-1];
    mag_a           = a_neg ? WIDTH'(-a_i) : a_i;
    mag_b           = b_neg ? WIDTH'(-b_i) : b_i;
    accept          = (state_q == MD_IDLE) && start_i && !annul_i;
    div_start       = accept && op_is_div(op_i) && (b_i != '0);
    mul_sum         = {1'b0, acc_q[PW-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : (WIDTH + 1)'(0));
    mul_next        = {mul_sum, acc_q[WIDTH-1:1]};
    mul_fixed       = neg_lo_q ? PW'(-mul_next) : mul_next;
    prod_fast       = PW'(mag_a) * PW'(mag_b);
    prod_fast_fixed = (a_neg ^ b_neg) ? PW'(-prod_fast) : prod_fast;
    quot_fixed      = neg_lo_q ? WIDTH'(-quot_c) : quot_c;
    rem_fixed       = neg_hi_q ? WIDTH'(-rem_c) : rem_c;
  end

  // Combinational so the issuing instruction is held in the very cycle it asks
  assign stallreq_o = !annul_i &&
                      (((state_q == MD_IDLE) && start_i) ||
                       (state_q == MD_MUL) || (state_q == MD_DIV));

  ex_muldiv_unit_div_core #(.WIDTH(WIDTH)) u_div_core (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .abort    (annul_i),
    .dividend (mag_a),
    .divisor  (mag_b),
    .done_c   (div_done_c),
    .quot_c   (quot_c),
    .rem_c    (rem_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= MD_IDLE;
      cnt_q         <= '0;
      mcand_q       <= '0;
      acc_q         <= '0;
      neg_lo_q      <= 1'b0;
      neg_hi_q      <= 1'b0;
      result_o      <= '0;
      ready_o       <= 1'b0;
      div_by_zero_o <= 1'b0;
    end else begin
      ready_o <= 1'b0;
      if (annul_i) begin
        state_q <= MD_IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          MD_IDLE: if (start_i) begin
            neg_lo_q <= a_neg ^ b_neg;
            neg_hi_q <= a_neg;
            if (op_is_div(op_i)) begin
              if (b_i == '0) begin
                result_o      <= {a_i, {WIDTH{1'b1}}};
                div_by_zero_o <= 1'b1;
                ready_o       <= 1'b1;
                state_q       <= MD_DONE;
              end else begin
                state_q <= MD_DIV;
              end
            end else if (MUL_FAST) begin
              result_o      <= prod_fast_fixed;
              div_by_zero_o <= 1'b0;
              ready_o       <= 1'b1;
              state_q       <= MD_DONE;
            end else begin
              acc_q   <= {WIDTH'(0), mag_b};
              mcand_q <= mag_a;
              cnt_q   <= '0;
              state_q <= MD_MUL;
            end
          end
          MD_MUL: begin
            acc_q <= mul_next;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
              cnt_q         <= '0;
              result_o      <= mul_fixed;
              div_by_zero_o <= 1'b0;
              ready_o       <= 1'b1;
              state_q       <= MD_DONE;
            end
          end
          MD_DIV: if (div_done_c) begin
            result_o      <= {rem_fixed, quot_fixed};
            div_by_zero_o <= 1'b0;
            ready_o       <= 1'b1;
            state_q       <= MD_DONE;
          end
          default: state_q <= MD_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: iterative instance plus a MUL_FAST instance.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start, start_f, annul;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic [63:0] result, result_f;
  logic        ready, ready_f, stall, stall_f, dbz, dbz_f;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.WIDTH(32), .MUL_FAST(1'b0)) dut (
    .clk(clk), .rst(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b), .annul_i(annul),
    .result_o(result), .ready_o(ready), .stallreq_o(stall), .div_by_zero_o(dbz)
  );

  ex_muldiv_unit #(.WIDTH(32), .MUL_FAST(1'b1)) dut_f (
    .clk(clk), .rst(rst), .start_i(start_f), .op_i(op), .a_i(a), .b_i(b), .annul_i(annul),
    .result_o(result_f), .ready_o(ready_f), .stallreq_o(stall_f), .div_by_zero_o(dbz_f)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op on the iterative unit; report first ready latency, result and pulse count
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output logic [63:0] res, output logic z, output int pulses);
    lat = -1; res = '0; z = 1'b0; pulses = 0;
    op = o; a = x; b = y; start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 1) start = 1'b0;
      if (ready) begin
        pulses++;
        if (lat < 0) begin lat = k; res = result; z = dbz; end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start_f = 1'b0; annul = 1'b0; op = 2'b00; a = '0; b = '0;
    tick(); tick();
    total++; if (result !== 64'h0) begin bad++; $display("FAIL reset_result got=%h want=0", result); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ready); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall); end
    total++; if (dbz !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b want=0", dbz); end
    total++; if (result_f !== 64'h0 || ready_f !== 1'b0) begin bad++; $display("FAIL reset_fast got=%h/%b want=0/0", result_f, ready_f); end
    rst = 1'b0;
    tick();
  endtask

  // MULT -3*5 with cycle-exact stall and ready checking
  task automatic test_mult_timing();
    logic exp_s, exp_r;
    op = 2'b00; a = 32'hFFFF_FFFD; b = 32'd5; start = 1'b1;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL mult_stall_T got=%b want=1", stall); end
    for (int k = 1; k <= 36; k++) begin
      tick();
      if (k == 1) start = 1'b0;
      exp_s = (k <= 32);
      exp_r = (k == 33);
      total++; if (stall !== exp_s) begin bad++; $display("FAIL mult_stall_T+%0d got=%b want=%b", k, stall, exp_s); end
      total++; if (ready !== exp_r) begin bad++; $display("FAIL mult_ready_T+%0d got=%b want=%b", k, ready, exp_r); end
      if (k == 33) begin
        total++; if (result !== 64'hFFFF_FFFF_FFFF_FFF1) begin bad++; $display("FAIL mult_result got=%h want=FFFFFFFFFFFFFFF1", result); end
      end
    end
  endtask

  task automatic test_mult_table();
    logic [1:0]  ops [6] = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01};
    logic [31:0] as  [6] = '{32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] bs  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 32'h0001_2345};
    logic [63:0] ex  [6] = '{64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFF_FFFF_FFD6, 64'h4000_0000_0000_0000,
                             64'h0000_0001_0000_0000, 64'h0000_0000_0000_0001, 64'h0};
    int lat, pulses; logic [63:0] res; logic z;
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], as[i], bs[i], lat, res, z, pulses);
      total++; if (lat != 33) begin bad++; $display("FAIL mul%0d_latency got=%0d want=33", i, lat); end
      total++; if (res !== ex[i]) begin bad++; $display("FAIL mul%0d_result got=%h want=%h", i, res, ex[i]); end
      total++; if (pulses != 1) begin bad++; $display("FAIL mul%0d_pulses got=%0d want=1", i, pulses); end
    end
  endtask

  task automatic test_mul_fast();
    logic [1:0]  ops [2] = '{2'b01, 2'b00};
    logic [31:0] as  [2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD};
    logic [31:0] bs  [2] = '{32'hFFFF_FFFF, 32'd5};
    logic [63:0] ex  [2] = '{64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFF_FFFF_FFF1};
    for (int i = 0; i < 2; i++) begin
      op = ops[i]; a = as[i]; b = bs[i]; start_f = 1'b1;
      tick();
      start_f = 1'b0;
      total++; if (ready_f !== 1'b1) begin bad++; $display("FAIL fast%0d_ready got=%b want=1", i, ready_f); end
      total++; if (result_f !== ex[i]) begin bad++; $display("FAIL fast%0d_result got=%h want=%h", i, result_f, ex[i]); end
      total++; if (stall_f !== 1'b0) begin bad++; $display("FAIL fast%0d_stall got=%b want=0", i, stall_f); end
      tick();
      total++; if (ready_f !== 1'b0) begin bad++; $display("FAIL fast%0d_ready_drop got=%b want=0", i, ready_f); end
      tick();
    end
  endtask

  task automatic test_div_zero();
    int lat, pulses; logic [63:0] res; logic z;
    run_op(2'b11, 32'h0000_1234, 32'h0, lat, res, z, pulses);
    total++; if (lat != 1) begin bad++; $display("FAIL divz_latency got=%0d want=1", lat); end
    total++; if (res !== 64'h0000_1234_FFFF_FFFF) begin bad++; $display("FAIL divz_result got=%h want=00001234FFFFFFFF", res); end
    total++; if (z !== 1'b1) begin bad++; $display("FAIL divz_flag got=%b want=1", z); end
    total++; if (pulses != 1) begin bad++; $display("FAIL divz_pulses got=%0d want=1", pulses); end
    run_op(2'b10, 32'hFFFF_FFFB, 32'h0, lat, res, z, pulses);
    total++; if (res !== 64'hFFFF_FFFB_FFFF_FFFF || z !== 1'b1 || lat != 1) begin
      bad++; $display("FAIL divz_signed got=%h/%b/%0d want=FFFFFFFBFFFFFFFF/1/1", res, z, lat); end
  endtask

  // Reset in the middle of a divide: everything clears, the divide never completes
  task automatic test_rst_mid();
    int pulses = 0;
    op = 2'b10; a = 32'hFFFF_FFF9; b = 32'd2; start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) start = 1'b0;
    end
    rst = 1'b1;
    tick();
    total++; if (result !== 64'h0) begin bad++; $display("FAIL rstmid_result got=%h want=0", result); end
    total++; if (ready !== 1'b0 || stall !== 1'b0 || dbz !== 1'b0) begin
      bad++; $display("FAIL rstmid_flags got=%b%b%b want=000", ready, stall, dbz); end
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (ready) pulses++;
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL rstmid_no_ready got=%0d want=0", pulses); end
  endtask

  task automatic test_div_table();
    logic [1:0]  ops [7] = '{2'b10, 2'b10, 2'b11, 2'b10, 2'b11, 2'b11, 2'b10};
    logic [31:0] as  [7] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd100, 32'd7, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFF8};
    logic [31:0] bs  [7] = '{32'd2, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'd9, 32'hFFFF_FFFD};
    logic [63:0] ex  [7] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0000_8000_0000, 64'h0000_0002_0000_000E,
                             64'h0000_0001_FFFF_FFFD, 64'h0000_0000_FFFF_FFFF, 64'h0000_0005_0000_0000,
                             64'hFFFF_FFFE_0000_0002};
    int lat, pulses; logic [63:0] res; logic z;
    for (int i = 0; i < 7; i++) begin
      run_op(ops[i], as[i], bs[i], lat, res, z, pulses);
      total++; if (lat != 33) begin bad++; $display("FAIL div%0d_latency got=%0d want=33", i, lat); end
      total++; if (res !== ex[i]) begin bad++; $display("FAIL div%0d_result got=%h want=%h", i, res, ex[i]); end
      total++; if (z !== 1'b0 || pulses != 1) begin bad++; $display("FAIL div%0d_flag_pulses got=%b/%0d want=0/1", i, z, pulses); end
    end
  endtask

  task automatic test_annul();
    int lat, pulses; logic [63:0] res; logic z;
    int early = 0;
    op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) start = 1'b0;
      if (ready) early++;
    end
    annul = 1'b1;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL annul_stall_drop got=%b want=0", stall); end
    tick();
    annul = 1'b0;
    total++; if (ready !== 1'b0 || early != 0) begin bad++; $display("FAIL annul_ready got=%b/%0d want=0/0", ready, early); end
    total++; if (result !== 64'hFFFF_FFFE_0000_0002) begin bad++; $display("FAIL annul_result got=%h want=FFFFFFFE00000002", result); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL annul_idle_stall got=%b want=0", stall); end
    op = 2'b01; a = 32'd6; b = 32'd7; start = 1'b1;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL annul_restart_stall got=%b want=1", stall); end
    run_op(2'b01, 32'd6, 32'd7, lat, res, z, pulses);
    total++; if (lat != 33) begin bad++; $display("FAIL annul_restart_latency got=%0d want=33", lat); end
    total++; if (res !== 64'h2A) begin bad++; $display("FAIL annul_restart_result got=%h want=2A", res); end
    // annul together with start in IDLE: request is not accepted
    op = 2'b01; a = 32'd2; b = 32'd2; start = 1'b1; annul = 1'b1;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL annul_start_stall got=%b want=0", stall); end
    tick();
    start = 1'b0; annul = 1'b0;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL annul_start_ignored got=%b want=0", stall); end
    tick();
  endtask

  // Start held high across DONE: second op accepted at T+34, one ready per op
  task automatic test_back_to_back();
    int pulses = 0;
    op = 2'b01; a = 32'd3; b = 32'd4; start = 1'b1;
    for (int k = 1; k <= 72; k++) begin
      tick();
      if (k == 33) begin
        total++; if (ready !== 1'b1 || result !== 64'hC) begin bad++; $display("FAIL b2b_first got=%b/%h want=1/C", ready, result); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL b2b_done_stall got=%b want=0", stall); end
        a = 32'd5; b = 32'd6;
      end
      if (k == 34) begin
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL b2b_accept_stall got=%b want=1", stall); end
      end
      if (k == 35) start = 1'b0;
      if (k == 67) begin
        total++; if (ready !== 1'b1 || result !== 64'h1E) begin bad++; $display("FAIL b2b_second got=%b/%h want=1/1E", ready, result); end
      end
      if (ready) pulses++;
    end
    total++; if (pulses != 2) begin bad++; $display("FAIL b2b_pulses got=%0d want=2", pulses); end
  endtask

  initial begin
    test_reset();
    test_mult_timing();
    test_mult_table();
    test_mul_fast();
    test_div_zero();
    test_rst_mid();
    test_div_table();
    test_annul();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
